// File: rtl/seq_mult_ctrl.sv
// seq_mult_ctrl: shift-and-add WAxWB unsigned multiplier (start/busy/done, product C), SEQ_MULT_EARLY_TERM_EN finishes zero operands in one cycle
module seq_mult_ctrl #(
  parameter int WA = 3,
  parameter int WB = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WA-1:0]    A,
  input  logic [WB-1:0]    B,
  output logic             busy,
  output logic             done,
  output logic [WA+WB-1:0] C
);
  localparam int CW = $clog2(WA + 1);
  localparam logic [CW-1:0] LAST = CW'(WA - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t        state;
  logic [CW-1:0] cnt;
  logic [WA-1:0] mq;
  logic [WB-1:0] mcand;
  logic [WB:0]   acc, sum;
  logic [WB+WA:0] nxt;
  always_comb begin
    sum = acc + (mq[0] ? {1'b0, mcand} : '0);
    nxt = {sum, mq} >> 1;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      mq    <= '0;
      mcand <= '0;
      acc   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      C     <= '0;
    end else if (start && state != RUN) begin
      mq    <= A;
      mcand <= B;
      acc   <= '0;
      cnt   <= '0;
`ifdef SEQ_MULT_EARLY_TERM_EN
      if (A == '0 || B == '0) begin
        state <= DONE;
        busy  <= 1'b0;
        done  <= 1'b1;
        C     <= '0;
      end else begin
        state <= RUN;
        busy  <= 1'b1;
        done  <= 1'b0;
      end
`else
      state <= RUN;
      busy  <= 1'b1;
      done  <= 1'b0;
`endif
    end else if (state == RUN) begin
      {acc, mq} <= nxt;
      cnt       <= cnt + CW'(1);
      if (cnt == LAST) begin
        state <= DONE;
        busy  <= 1'b0;
        done  <= 1'b1;
        C     <= nxt[WA+WB-1:0];
      end
    end else begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_seq_mult_ctrl.sv
// tb_seq_mult_ctrl: directed, exhaustive and random checks of seq_mult_ctrl against a cycle-count/product model
module tb_seq_mult_ctrl;
  localparam int WA = 3;
  localparam int WB = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic [WA-1:0] a = '0;
  logic [WB-1:0] b = '0;
  logic busy, done;
  logic [WA+WB-1:0] c;
  int tests = 0;
  int fails = 0;
  int m_rem = 0;
  int m_done = 0;
  int m_c = 0;
  int m_pend = 0;
  int n_done = 0;
  int m_cmp = 0;
  seq_mult_ctrl #(.WA(WA), .WB(WB)) dut (
    .clk(clk), .reset(reset), .start(start), .A(a), .B(b),
    .busy(busy), .done(done), .C(c)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic step();
    @(posedge clk);
    if (reset) begin
      m_rem = 0;
      m_done = 0;
      m_c = 0;
    end else if (m_rem > 0) begin
      m_rem--;
      m_done = (m_rem == 0);
      if (m_rem == 0) begin
        m_c = m_pend;
        m_cmp++;
      end
    end else begin
      m_done = 0;
      if (start) begin
        m_pend = int'(a) * int'(b);
`ifdef SEQ_MULT_EARLY_TERM_EN
        if (m_pend == 0) begin
          m_done = 1;
          m_c = 0;
          m_cmp++;
        end else m_rem = WA;
`else
        m_rem = WA;
`endif
      end
    end
    #1;
    if (done) n_done++;
    chk("busy", 32'(busy), 32'(m_rem > 0));
    chk("done", 32'(done), 32'(m_done));
    chk("c", 32'(c), 32'(m_c));
  endtask
  task automatic go(input int x, input int y);
    a = WA'(x);
    b = WB'(y);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask
  initial begin
    int sweep_done;
    step();
    step();
    chk("rst_c", 32'(c), 0);
    chk("rst_busy", 32'(busy), 0);
    reset = 1'b0;
    step();
    go(5, 13);
    chk("busy_t1", 32'(busy), 1);
    repeat (3) step();
    chk("done_t4", 32'(done), 1);
    chk("c_65", 32'(c), 65);
    repeat (3) step();
    chk("c_hold", 32'(c), 65);
    go(7, 15);
    repeat (4) step();
    chk("c_105", 32'(c), 105);
    go(0, 9);
    repeat (5) step();
    chk("c_zero", 32'(c), 0);
    a = 3; b = 4; start = 1'b1;
    step();
    a = 6; b = 11;
    repeat (4) step();
    chk("b2b_12", 32'(c), 12);
    start = 1'b0;
    repeat (4) step();
    chk("b2b_66", 32'(c), 66);
    go(5, 13);
    step();
    a = 1; b = 1; start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    chk("ign_65", 32'(c), 65);
    repeat (2) step();
    go(7, 15);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_c", 32'(c), 0);
    chk("abort_busy", 32'(busy), 0);
    repeat (5) step();
    sweep_done = n_done;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 16; j++) begin
        int budget;
        go(i, j);
        budget = 0;
        while (!done && budget < 10) begin
          step();
          budget++;
        end
        if (!done) chk("timeout", 0, 1);
        chk("sweep", 32'(c), 32'(i * j));
      end
    chk("sweep_dones", 32'(n_done - sweep_done), 128);
    for (int k = 0; k < 400; k++) begin
      a = WA'($urandom);
      b = WB'($urandom);
      start = ($urandom_range(0, 2) != 0);
      reset = ($urandom_range(0, 40) == 0);
      step();
    end
    reset = 1'b0;
    start = 1'b0;
    repeat (6) step();
    chk("done_total", 32'(n_done), 32'(m_cmp));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
